// File: rtl/register_file_if.sv
// Bus bundle for the register file: one write port, one reserve port,
// two combinational read ports and the scoreboard status outputs.
interface register_file_if #(
  parameter int WIDTH  = 24,
  parameter int ADDR_W = 4
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [WIDTH-1:0]  wdata;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic [ADDR_W-1:0] ra_addr;
  logic [WIDTH-1:0]  ra_data;
  logic              ra_busy;
  logic [ADDR_W-1:0] rb_addr;
  logic [WIDTH-1:0]  rb_data;
  logic              rb_busy;
  logic              rsv_conflict;
  logic [ADDR_W:0]   busy_count;

  // The control unit / pipeline side drives addresses and write data
  modport master (
    output we, waddr, wdata, rsv_en, rsv_addr, ra_addr, rb_addr,
    input  ra_data, ra_busy, rb_data, rb_busy, rsv_conflict, busy_count
  );

  // The register file itself
  modport slave (
    input  we, waddr, wdata, rsv_en, rsv_addr, ra_addr, rb_addr,
    output ra_data, ra_busy, rb_data, rb_busy, rsv_conflict, busy_count
  );
endinterface

// File: rtl/register_file.sv
// Multi-entry register file with per-entry pending bits. A reserve marks an
// entry as awaiting a multicycle result; the write that delivers the result
// clears the mark. Reads are combinational, with optional same-cycle write
// forwarding and an optional hardwired-zero entry 0.
module register_file #(
  parameter int WIDTH    = 24,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic            clk,
  input logic            reset,
  register_file_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_next;
  logic [ADDR_W:0]  count_next;
  logic [ADDR_W:0]  busy_count_q;
  logic             rsv_conflict_q;
  logic             wr_ok;
  logic             rsv_ok;

  // Writes and reserves aimed at a hardwired-zero entry 0 are dropped entirely
  always_comb begin
    wr_ok  = bus.we;
    rsv_ok = bus.rsv_en;
    if (ZERO_REG != 0) begin
      if (bus.waddr == '0)    wr_ok  = 1'b0;
      if (bus.rsv_addr == '0) rsv_ok = 1'b0;
    end
  end

  // Next pending vector: write clears first, reserve sets last so a new producer wins
  always_comb begin
    busy_next = busy;
    if (wr_ok)  busy_next[bus.waddr]    = 1'b0;
    if (rsv_ok) busy_next[bus.rsv_addr] = 1'b1;
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_next = count_next + {{ADDR_W{1'b0}}, busy_next[i]};
    end
  end

  // Storage, scoreboard and registered status update
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      busy           <= '0;
      rsv_conflict_q <= 1'b0;
      busy_count_q   <= '0;
    end else begin
      if (wr_ok) mem[bus.waddr] <= bus.wdata;
      busy           <= busy_next;
      rsv_conflict_q <= rsv_ok && busy[bus.rsv_addr];
      busy_count_q   <= count_next;
    end
  end

  // Read port A: array lookup, then forwarding, then the zero-entry override
  always_comb begin
    bus.ra_data = mem[bus.ra_addr];
    bus.ra_busy = busy[bus.ra_addr];
    if (BYPASS != 0 && bus.we && bus.waddr == bus.ra_addr) begin
      bus.ra_data = bus.wdata;
      bus.ra_busy = 1'b0;
    end
    if (ZERO_REG != 0 && bus.ra_addr == '0) begin
      bus.ra_data = '0;
      bus.ra_busy = 1'b0;
    end
  end

  // Read port B: identical path to port A
  always_comb begin
    bus.rb_data = mem[bus.rb_addr];
    bus.rb_busy = busy[bus.rb_addr];
    if (BYPASS != 0 && bus.we && bus.waddr == bus.rb_addr) begin
      bus.rb_data = bus.wdata;
      bus.rb_busy = 1'b0;
    end
    if (ZERO_REG != 0 && bus.rb_addr == '0) begin
      bus.rb_data = '0;
      bus.rb_busy = 1'b0;
    end
  end

  assign bus.rsv_conflict = rsv_conflict_q;
  assign bus.busy_count   = busy_count_q;

endmodule
